prefix_add_arbiter: RTL

Two-requester arbiter and sequencer for the shared pipelined parallel-prefix adder in the butterfly datapath. It grants one request per cycle by round-robin and converts subtract requests into add-with-inverted-operand form. It drives the adder's registered inputs, tracks in-flight operations in a latency-matched tag pipeline, and routes each result back to the requester that issued it. Typical requesters are the butterfly add path and the butterfly subtract path.

---
 rtl/prefix_add_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/prefix_add_arbiter.sv
// Round-robin arbiter and sequencer for the shared pipelined prefix adder.
// Subtracts are issued as a + ~b + 1; results are routed back by a latency-matched tag pipeline.
module prefix_add_arbiter #(
  parameter int unsigned W    = 32,
  parameter int unsigned TAGW = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req0_vld,
  output logic            req0_rdy,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req0_sub,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_vld,
  output logic            req1_rdy,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic            req1_sub,
  input  logic [TAGW-1:0] req1_tag,
  output logic            add_vld,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  output logic            add_cin,
  input  logic [W-1:0]    add_sum,
  input  logic            add_cout,
  output logic            rsp0_vld,
  output logic [W-1:0]    rsp0_sum,
  output logic            rsp0_cout,
  output logic [TAGW-1:0] rsp0_tag,
  output logic            rsp1_vld,
  output logic [W-1:0]    rsp1_sum,
  output logic            rsp1_cout,
  output logic [TAGW-1:0] rsp1_tag,
  output logic            busy
);

  typedef struct packed {
    logic            vld;
    logic            id;
    logic [TAGW-1:0] tag;
  } stage_t;

  logic            ptr_q, ptr_d;
  logic            add_vld_q, add_vld_d;
  logic [W-1:0]    add_a_q, add_a_d;
  logic [W-1:0]    add_b_q, add_b_d;
  logic            add_cin_q, add_cin_d;
  logic            add_id_q, add_id_d;
  logic [TAGW-1:0] add_tag_q, add_tag_d;
  stage_t [LAT-1:0] pipe_q, pipe_d;
  logic            rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
  logic [W-1:0]    rsp0_sum_q, rsp0_sum_d, rsp1_sum_q, rsp1_sum_d;
  logic            rsp0_cout_q, rsp0_cout_d, rsp1_cout_q, rsp1_cout_d;
  logic [TAGW-1:0] rsp0_tag_q, rsp0_tag_d, rsp1_tag_q, rsp1_tag_d;
  logic            busy_q, busy_d;
  logic            hs0, hs1, fire;

  // Contention resolved by ptr; a lone requester is always ready.
  assign req0_rdy = ~flush & (~req1_vld | ~ptr_q);
  assign req1_rdy = ~flush & (~req0_vld | ptr_q);
  assign hs0      = req0_vld & req0_rdy;
  assign hs1      = req1_vld & req1_rdy;

  always_comb begin
    ptr_d     = ptr_q;
    add_vld_d = 1'b0;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
    add_id_d  = add_id_q;
    add_tag_d = add_tag_q;
    if (hs0) begin
      ptr_d     = 1'b1;
      add_vld_d = 1'b1;
      add_a_d   = req0_a;
      add_b_d   = req0_sub ? ~req0_b : req0_b;
      add_cin_d = req0_sub;
      add_id_d  = 1'b0;
      add_tag_d = req0_tag;
    end else if (hs1) begin
      ptr_d     = 1'b0;
      add_vld_d = 1'b1;
      add_a_d   = req1_a;
      add_b_d   = req1_sub ? ~req1_b : req1_b;
      add_cin_d = req1_sub;
      add_id_d  = 1'b1;
      add_tag_d = req1_tag;
    end
  end

  // Tag pipeline mirrors the adder depth; flush kills every stage.
  always_comb begin
    pipe_d[0].vld = add_vld_q & ~flush;
    pipe_d[0].id  = add_id_q;
    pipe_d[0].tag = add_tag_q;
    for (int i = 1; i < int'(LAT); i++) begin
      pipe_d[i]     = pipe_q[i-1];
      pipe_d[i].vld = pipe_q[i-1].vld & ~flush;
    end
    busy_d = add_vld_d;
    for (int i = 0; i < int'(LAT); i++) begin
      busy_d = busy_d | pipe_d[i].vld;
    end
  end

  assign fire = pipe_q[LAT-1].vld & ~flush;

  always_comb begin
    rsp0_vld_d  = fire & ~pipe_q[LAT-1].id;
    rsp1_vld_d  = fire & pipe_q[LAT-1].id;
    rsp0_sum_d  = rsp0_vld_d ? add_sum : rsp0_sum_q;
    rsp0_cout_d = rsp0_vld_d ? add_cout : rsp0_cout_q;
    rsp0_tag_d  = rsp0_vld_d ? pipe_q[LAT-1].tag : rsp0_tag_q;
    rsp1_sum_d  = rsp1_vld_d ? add_sum : rsp1_sum_q;
    rsp1_cout_d = rsp1_vld_d ? add_cout : rsp1_cout_q;
    rsp1_tag_d  = rsp1_vld_d ? pipe_q[LAT-1].tag : rsp1_tag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= 1'b0;
      add_vld_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      add_id_q    <= 1'b0;
      add_tag_q   <= '0;
      pipe_q      <= '0;
      rsp0_vld_q  <= 1'b0;
      rsp0_sum_q  <= '0;
      rsp0_cout_q <= 1'b0;
      rsp0_tag_q  <= '0;
      rsp1_vld_q  <= 1'b0;
      rsp1_sum_q  <= '0;
      rsp1_cout_q <= 1'b0;
      rsp1_tag_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      add_vld_q   <= add_vld_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      add_id_q    <= add_id_d;
      add_tag_q   <= add_tag_d;
      pipe_q      <= pipe_d;
      rsp0_vld_q  <= rsp0_vld_d;
      rsp0_sum_q  <= rsp0_sum_d;
      rsp0_cout_q <= rsp0_cout_d;
      rsp0_tag_q  <= rsp0_tag_d;
      rsp1_vld_q  <= rsp1_vld_d;
      rsp1_sum_q  <= rsp1_sum_d;
      rsp1_cout_q <= rsp1_cout_d;
      rsp1_tag_q  <= rsp1_tag_d;
      busy_q      <= busy_d;
    end
  end

  assign add_vld   = add_vld_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp0_vld  = rsp0_vld_q;
  assign rsp0_sum  = rsp0_sum_q;
  assign rsp0_cout = rsp0_cout_q;
  assign rsp0_tag  = rsp0_tag_q;
  assign rsp1_vld  = rsp1_vld_q;
  assign rsp1_sum  = rsp1_sum_q;
  assign rsp1_cout = rsp1_cout_q;
  assign rsp1_tag  = rsp1_tag_q;
  assign busy      = busy_q;

endmodule
